serial_subtractor_32_bit: RTL

SERIAL_SUBTRACTOR_32_BIT -- requirements
Module: serial_subtractor_32_bit

---
 rtl/serial_subtractor_32_bit_pkg.sv | 18 +
 rtl/serial_subtractor_32_bit_full_subtractor_slice.sv | 16 +
 rtl/serial_subtractor_32_bit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_subtractor_32_bit_pkg.sv
// Shared definitions for the serial 32-bit subtractor.
// Holds the FSM state encoding, the datapath width and the slice-count helper.
package serial_subtractor_32_bit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of RUN cycles needed to cover the full word with the given slice width.
  function automatic int nslice(input int slice_w);
    return DATA_W / slice_w;
  endfunction

endpackage

// File: rtl/serial_subtractor_32_bit_full_subtractor_slice.sv
// Combinational W-bit subtractor slice: diff = a - b - borrow_in.
// borrow_out is set when the true result is negative.
module full_subtractor_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         borrow_in,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  // One extra bit on the left captures the borrow as the sign of the widened result.
  assign {borrow_out, diff} = {1'b0, a} - {1'b0, b} - (W + 1)'(borrow_in);

endmodule

// File: rtl/serial_subtractor_32_bit.sv
// Serial 32-bit subtractor: computes a - b - bin one SLICE_W-bit slice per cycle,
// LSB slice first, with the borrow carried between slices in a register.
// SLICE_W must be 1, 2, 4, 8, 16 or 32.
// Optional feature: define SUB_OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module serial_subtractor_32_bit
  import serial_subtractor_32_bit_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] diff,
  output logic        bout
`ifdef SUB_OVERFLOW_FLAG_EN
  ,
  output logic        ovf
`endif
);

  localparam int NSLICE = nslice(SLICE_W);
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t              state;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   res_q;
  logic                borrow_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                accept;

  logic [SLICE_W-1:0]  slice_diff;
  logic                slice_borrow;

`ifdef SUB_OVERFLOW_FLAG_EN
  // Operand sign bits are kept aside because the operand registers shift out during RUN.
  logic                a_msb_q;
  logic                b_msb_q;
`endif

  // A new request is taken in IDLE and in DONE (back-to-back); RUN ignores start.
  assign accept = start && (state != RUN);

  // The single slice subtractor always sees the lowest unprocessed slice.
  full_subtractor_slice #(
    .W(SLICE_W)
  ) u_slice (
    .a         (a_q[SLICE_W-1:0]),
    .b         (b_q[SLICE_W-1:0]),
    .borrow_in (borrow_q),
    .diff      (slice_diff),
    .borrow_out(slice_borrow)
  );

  // FSM, slice counter, operand/result shift registers and registered outputs.
  // done/diff/bout are loaded while in DONE, so they are visible the cycle after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here, including the operand and result registers, gets a
    // defined reset value so an aborted operation leaves nothing stale behind.
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the values
      // from before this edge and the later accept block may override state safely.
      done <= 1'b0;

      case (state)
        IDLE: begin
          state <= IDLE;
        end

        RUN: begin
          a_q      <= a_q >> SLICE_W;
          b_q      <= b_q >> SLICE_W;
          res_q    <= (res_q >> SLICE_W) | (DATA_W'(slice_diff) << (DATA_W - SLICE_W));
          borrow_q <= slice_borrow;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NSLICE - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end

        DONE: begin
          done  <= 1'b1;
          diff  <= res_q;
          bout  <= borrow_q;
`ifdef SUB_OVERFLOW_FLAG_EN
          // Overflow: operands of opposite sign and result sign differs from the minuend.
          ovf   <= (a_msb_q ^ b_msb_q) & (res_q[DATA_W-1] ^ a_msb_q);
`endif
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (accept) begin
        a_q      <= a;
        b_q      <= b;
        borrow_q <= bin;
        cnt_q    <= '0;
        state    <= RUN;
        busy     <= 1'b1;
`ifdef SUB_OVERFLOW_FLAG_EN
        a_msb_q  <= a[DATA_W-1];
        b_msb_q  <= b[DATA_W-1];
`endif
      end
    end
  end

endmodule
